dmem_arbiter: RTL and testbench

//   Shares the single-port data RAM between the core load/store path (port 0) and a

---
 rtl/dmem_if.sv | 33 +++
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Bundle of requester, arbiter status and RAM-side signals for the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport is its environment (requesters + RAM).
interface dmem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              dbg_lock;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              ram_wen;
  logic              ram_ren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, dbg_lock, ram_rdata,
    output gnt, rvalid, rdata, ram_wen, ram_ren, ram_addr, ram_wdata, busy
  );

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, dbg_lock, ram_rdata,
    input  gnt, rvalid, rdata, ram_wen, ram_ren, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (core = port 0, debug = port 1) in front of a single-port data RAM.
// Round-robin on contention, sticky debug ownership under dbg_lock, all outputs registered.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              take;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              win_l;
  logic              we_l;
  logic              rr_last;
  logic              owner;
  logic              lock_hold;

  // Lock only sticks to a debug master that actually won the last arbitration.
  assign lock_hold = bus.dbg_lock & owner;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and winner selection
  always_comb begin
    state_next = state;
    take       = 1'b0;
    win        = 1'b0;
    case (state)
      IDLE: begin
        if (lock_hold) begin
          take = bus.req[1];
          win  = 1'b1;
        end else if (bus.req == 2'b11) begin
          take = 1'b1;
          win  = ~rr_last;
        end else if (bus.req != 2'b00) begin
          take = 1'b1;
          win  = bus.req[1];
        end else begin
          take = 1'b0;
          win  = 1'b0;
        end
        if (take) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE:   state_next = we_l ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields of the selected port
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = {ADDR_W{1'b0}};
    sel_wdata = {DATA_W{1'b0}};
    if (win) begin
      sel_we    = bus.we[1];
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end else begin
      sel_we    = bus.we[0];
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
    end
  end

  // Request latch, RAM strobes, handshake pulses and read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_l         <= 1'b0;
      we_l          <= 1'b0;
      rr_last       <= 1'b1;
      owner         <= 1'b0;
      bus.gnt       <= 2'b00;
      bus.rvalid    <= 2'b00;
      bus.rdata     <= {DATA_W{1'b0}};
      bus.ram_wen   <= 1'b0;
      bus.ram_ren   <= 1'b0;
      bus.ram_addr  <= {ADDR_W{1'b0}};
      bus.ram_wdata <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      bus.busy <= (state_next != IDLE);
      if (take) begin
        win_l         <= win;
        we_l          <= sel_we;
        rr_last       <= win;
        owner         <= win;
        bus.gnt       <= win ? 2'b10 : 2'b01;
        bus.ram_wen   <= sel_we;
        bus.ram_ren   <= ~sel_we;
        bus.ram_addr  <= sel_addr;
        bus.ram_wdata <= sel_wdata;
      end else begin
        bus.gnt       <= 2'b00;
        bus.ram_wen   <= 1'b0;
        bus.ram_ren   <= 1'b0;
        bus.ram_addr  <= {ADDR_W{1'b0}};
        bus.ram_wdata <= {DATA_W{1'b0}};
      end
      // RAM data is combinational from ram_addr, so it is valid at the edge closing ISSUE.
      if ((state == ISSUE) && !we_l) begin
        bus.rdata  <= bus.ram_rdata;
        bus.rvalid <= win_l ? 2'b10 : 2'b01;
      end else begin
        bus.rvalid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural RAM, reference memory image and
// a read scoreboard filled when requests are driven and drained on rvalid.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    port;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ram_load;
  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];
  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {24'hC0FFEE, a};
  endfunction

  assign bus.ram_rdata = ram[bus.ram_addr];

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i[7:0]);
    end else if (bus.ram_wen) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.rvalid, bus.ram_wen, bus.ram_ren, bus.busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got gnt=%b rvalid=%b wen=%b ren=%b busy=%b want all 0",
               bus.gnt, bus.rvalid, bus.ram_wen, bus.ram_ren, bus.busy);
    end
    n_cmp++;
    if ({bus.ram_addr, bus.ram_wdata, bus.rdata} !== {(AW+2*DW){1'b0}}) begin
      n_err++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0", bus.ram_addr, bus.ram_wdata, bus.rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle got gnt=%b busy=%b want 00/0", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_core_read();
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 8'h10;
    exp_q.push_back({2'b01, ref_mem[8'h10]});
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.ram_ren, bus.ram_wen, bus.busy} !== 5'b01101) begin
      n_err++;
      $display("FAIL rd_issue got gnt=%b ren=%b wen=%b busy=%b want 01/1/0/1", bus.gnt, bus.ram_ren, bus.ram_wen, bus.busy);
    end
    n_cmp++;
    if (bus.ram_addr !== 8'h10) begin
      n_err++;
      $display("FAIL rd_addr got %h want 10", bus.ram_addr);
    end
    bus.req = 2'b00;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.rvalid, bus.gnt, bus.ram_ren} !== {e.port, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL rd_rvalid got rvalid=%b gnt=%b ren=%b want %b/00/0", bus.rvalid, bus.gnt, bus.ram_ren, e.port);
    end
    n_cmp++;
    if (bus.rdata !== e.data) begin
      n_err++;
      $display("FAIL rd_data got %h want %h", bus.rdata, e.data);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.rvalid} !== 3'b000) begin
      n_err++;
      $display("FAIL rd_done got busy=%b rvalid=%b want 0/00", bus.busy, bus.rvalid);
    end
  endtask

  task automatic test_debug_write();
    bus.req = 2'b10; bus.we = 2'b10; bus.addr1 = 8'h20; bus.wdata1 = 32'h12345678;
    ref_mem[8'h20] = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.ram_wen, bus.ram_ren} !== 4'b1010) begin
      n_err++;
      $display("FAIL wr_issue got gnt=%b wen=%b ren=%b want 10/1/0", bus.gnt, bus.ram_wen, bus.ram_ren);
    end
    n_cmp++;
    if ({bus.ram_addr, bus.ram_wdata} !== {8'h20, 32'h12345678}) begin
      n_err++;
      $display("FAIL wr_fields got addr=%h wdata=%h want 20/12345678", bus.ram_addr, bus.ram_wdata);
    end
    bus.req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({bus.rvalid, bus.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL wr_norvalid got rvalid=%b busy=%b want 00/0", bus.rvalid, bus.busy);
    end
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 8'h20;
    exp_q.push_back({2'b01, ref_mem[8'h20]});
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 2'b01) begin
      n_err++;
      $display("FAIL wr_rdback_gnt got %b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.rvalid, bus.rdata} !== {e.port, e.data}) begin
      n_err++;
      $display("FAIL wr_rdback got rvalid=%b rdata=%h want %b/%h", bus.rvalid, bus.rdata, e.port, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    bus.req = 2'b10; bus.we = 2'b00; bus.addr1 = 8'h10;
    exp_q.push_back({2'b10, ref_mem[8'h10]});
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.ram_ren} !== 3'b101) begin
      n_err++;
      $display("FAIL drop_gnt got gnt=%b ren=%b want 10/1", bus.gnt, bus.ram_ren);
    end
    bus.req = 2'b00;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.rvalid, bus.rdata} !== {e.port, e.data}) begin
      n_err++;
      $display("FAIL drop_read got rvalid=%b rdata=%h want %b/%h", bus.rvalid, bus.rdata, e.port, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [AW-1:0] a;
    a = 8'hFD;
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = a; bus.wdata0 = 32'hB0B0_0000;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 8);
      n_cmp++;
      if ({bus.gnt, bus.ram_wen, bus.ram_addr, bus.ram_wdata} !== {2'b01, 1'b1, a, 32'hB0B0_0000 + k}) begin
        n_err++;
        $display("FAIL b2b_wr%0d got gnt=%b wen=%b addr=%h wdata=%h want 01/1/%h/%h", k,
                 bus.gnt, bus.ram_wen, bus.ram_addr, bus.ram_wdata, a, 32'hB0B0_0000 + k);
      end
      if (k > 0) begin
        n_cmp++;
        if (n !== 2) begin
          n_err++;
          $display("FAIL b2b_spacing got %0d cycles want 2", n);
        end
      end
      ref_mem[a] = 32'hB0B0_0000 + k;
      a = a + 8'd1;
      bus.addr0  = a;
      bus.wdata0 = 32'hB0B0_0001 + k;
      if (k == 2) bus.req = 2'b00;
    end
    @(negedge clk);
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 8'hFF;
    exp_q.push_back({2'b01, ref_mem[8'hFF]});
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.rvalid, bus.rdata} !== {e.port, e.data}) begin
      n_err++;
      $display("FAIL b2b_rdback got rvalid=%b rdata=%h want %b/%h", bus.rvalid, bus.rdata, e.port, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n;
    logic [1:0] want;
    logic [1:0] prev;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 2'b11; bus.we = 2'b00; bus.addr0 = 8'h30; bus.addr1 = 8'h31;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_q.push_back({want, ref_mem[(k % 2 == 0) ? 8'h30 : 8'h31]});
    end
    prev = 2'b00;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n = 0;
      do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 8);
      n_cmp++;
      if (bus.gnt !== e.port) begin
        n_err++;
        $display("FAIL rr_gnt%0d got %b want %b", k, bus.gnt, e.port);
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.gnt === prev) begin
          n_err++;
          $display("FAIL rr_repeat%0d got %b twice want alternation", k, bus.gnt);
        end
      end
      prev = bus.gnt;
      if (k == 3) bus.req = 2'b00;
      @(negedge clk);
      n_cmp++;
      if ({bus.rvalid, bus.rdata} !== {e.port, e.data}) begin
        n_err++;
        $display("FAIL rr_read%0d got rvalid=%b rdata=%h want %b/%h", k, bus.rvalid, bus.rdata, e.port, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lock();
    int n;
    int blocked;
    bus.dbg_lock = 1'b1;
    bus.req = 2'b10; bus.we = 2'b11; bus.addr1 = 8'h40; bus.wdata1 = 32'h4040_4040;
    bus.addr0 = 8'h50; bus.wdata0 = 32'h5050_5050;
    ref_mem[8'h40] = 32'h4040_4040;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 8);
    n_cmp++;
    if (bus.gnt !== 2'b10) begin
      n_err++;
      $display("FAIL lock_first got %b want 10", bus.gnt);
    end
    bus.req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 8);
      n_cmp++;
      if (bus.gnt !== 2'b10) begin
        n_err++;
        $display("FAIL lock_hold%0d got %b want 10", k, bus.gnt);
      end
      if (k == 2) bus.req = 2'b01;
    end
    blocked = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.gnt !== 2'b00) blocked++;
    end
    n_cmp++;
    if (blocked !== 0) begin
      n_err++;
      $display("FAIL lock_block_core got %0d grants want 0", blocked);
    end
    bus.dbg_lock = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt === 2'b00 && n < 8);
    n_cmp++;
    if ({bus.gnt, bus.ram_addr, bus.ram_wdata} !== {2'b01, 8'h50, 32'h5050_5050}) begin
      n_err++;
      $display("FAIL unlock_core got gnt=%b addr=%h wdata=%h want 01/50/50505050", bus.gnt, bus.ram_addr, bus.ram_wdata);
    end
    ref_mem[8'h50] = 32'h5050_5050;
    bus.req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int bad;
    bus.req = 2'b01; bus.we = 2'b00; bus.addr0 = 8'h10;
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 2'b01) begin
      n_err++;
      $display("FAIL arst_pre got gnt=%b want 01", bus.gnt);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.gnt, bus.rvalid, bus.ram_wen, bus.ram_ren, bus.busy, bus.ram_addr} !== {7'b0, 8'h00}) begin
      n_err++;
      $display("FAIL arst_clear got gnt=%b rvalid=%b wen=%b ren=%b busy=%b addr=%h want 0",
               bus.gnt, bus.rvalid, bus.ram_wen, bus.ram_ren, bus.busy, bus.ram_addr);
    end
    bus.req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({bus.gnt, bus.rvalid, bus.ram_wen, bus.ram_ren} !== 6'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL arst_quiet got %0d active cycles want 0", bad);
    end
    bus.req = 2'b01;
    exp_q.push_back({2'b01, ref_mem[8'h10]});
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt, bus.ram_ren} !== 3'b011) begin
      n_err++;
      $display("FAIL arst_regnt got gnt=%b ren=%b want 01/1", bus.gnt, bus.ram_ren);
    end
    bus.req = 2'b00;
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({bus.rvalid, bus.rdata} !== {e.port, e.data}) begin
      n_err++;
      $display("FAIL arst_reread got rvalid=%b rdata=%h want %b/%h", bus.rvalid, bus.rdata, e.port, e.data);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ram_load = 1'b1;
    bus.req = 2'b00; bus.we = 2'b00; bus.dbg_lock = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00;
    bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i[7:0]);
    @(negedge clk);
    ram_load = 1'b0;
    test_reset();
    test_core_read();
    test_debug_write();
    test_req_drop();
    test_back_to_back();
    test_contention();
    test_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
